// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the single-cycle core.
// Serves a word-addressed 64-bit RAM below MMIO_BASE and four MMIO
// registers at and above it: TX (debug FIFO push / count), STATUS,
// CYCLE (free-running counter) and DROPS (saturating rejected-push count).
// Loads are combinational from ALUResult and registered state only.
//
// Debug stream handshake: dbg_valid is high whenever the FIFO holds at
// least one entry and dbg_data then shows the oldest entry. An entry is
// consumed at the rising edge where dbg_valid and dbg_ready are both high.
// While dbg_valid is high and dbg_ready is low, dbg_data does not change.
// dbg_ready may be driven independently of dbg_valid.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [63:0] MMIO_BASE   = 64'h1000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [63:0] ALUResult,
  input  logic [63:0] WriteData,
  output logic [63:0] ReadData,
  output logic        dbg_valid,
  input  logic        dbg_ready,
  output logic [63:0] dbg_data,
  output logic        dbg_ovf
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  // Address decode
  logic          is_mmio;
  logic [63:0]   mmio_off;
  logic [AW-1:0] ram_idx;
  logic          reg_hit;
  logic          sel_tx;
  logic          sel_status;
  logic          unused_off_bits;

  // RAM storage (not reset)
  logic [63:0] mem_q [DEPTH_WORDS];

  // FIFO and register state
  logic [63:0]   fifo_q   [FIFO_DEPTH];
  logic [63:0]   fifo_d   [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          ovf_q,    ovf_d;
  logic [31:0]   drops_q,  drops_d;
  logic [63:0]   cycle_q,  cycle_d;

  // Handshake / push classification
  logic full;
  logic empty;
  logic pop;
  logic push;
  logic push_ok;
  logic drop;
  logic ovf_clr;

  assign is_mmio         = (ALUResult >= MMIO_BASE);
  assign mmio_off        = ALUResult - MMIO_BASE;
  assign ram_idx         = ALUResult[3 +: AW];
  assign reg_hit         = is_mmio && (mmio_off[63:5] == '0);
  assign sel_tx          = reg_hit && (mmio_off[4:3] == 2'd0);
  assign sel_status      = reg_hit && (mmio_off[4:3] == 2'd1);
  // Byte lane bits of the offset play no part in decode (64-bit aligned).
  assign unused_off_bits = ^mmio_off[2:0];

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign pop     = !empty && dbg_ready;
  assign push    = MemWrite && sel_tx;
  // A pop frees a slot in the same edge, so a full FIFO still accepts.
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;
  assign ovf_clr = MemWrite && sel_status && WriteData[0];

  assign dbg_valid = !empty;
  assign dbg_data  = empty ? 64'd0 : fifo_q[rd_ptr_q];
  assign dbg_ovf   = ovf_q;

  // RAM store port; reads below see the pre-edge contents.
  always_ff @(posedge clk) begin
    if (MemWrite && !is_mmio) begin
      mem_q[ram_idx] <= WriteData;
    end
  end

  // Next-state for FIFO, overflow flag and counters.
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    drops_d  = drops_q;
    cycle_d  = cycle_q + 64'd1;

    if (push_ok) begin
      fifo_d[wr_ptr_q] = WriteData;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + {{PW{1'b0}}, push_ok} - {{PW{1'b0}}, pop};

    // A new overflow takes priority over a software clear.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end

    if (drop && (drops_q != 32'hFFFF_FFFF)) begin
      drops_d = drops_q + 32'd1;
    end
  end

  // State registers; reset discards FIFO contents at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      drops_q  <= '0;
      cycle_q  <= '0;
    end else begin
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      drops_q  <= drops_d;
      cycle_q  <= cycle_d;
    end
  end

  // Load mux: RAM below MMIO_BASE, decoded registers above, zero elsewhere.
  always_comb begin
    ReadData = 64'd0;
    if (!is_mmio) begin
      ReadData = mem_q[ram_idx];
    end else if (reg_hit) begin
      case (mmio_off[4:3])
        2'd0:    ReadData = 64'(count_q);
        2'd1:    ReadData = {60'd0, ovf_q, full, empty, 1'b0};
        2'd2:    ReadData = cycle_q;
        default: ReadData = {32'd0, drops_q};
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed scenarios followed by randomized traffic,
// checked against a queue/array reference model of the memory map.
module tb_dmem_responder;

  localparam int          DW   = 256;
  localparam int          FD   = 4;
  localparam logic [63:0] BASE = 64'h1000_0000;
  localparam logic [63:0] A_TX = BASE;
  localparam logic [63:0] A_ST = BASE + 64'h08;
  localparam logic [63:0] A_CY = BASE + 64'h10;
  localparam logic [63:0] A_DR = BASE + 64'h18;
  localparam logic [63:0] A_UN = BASE + 64'h20;
  localparam logic [63:0] PAT  = 64'hDEAD_BEEF_0123_4567;

  // ---------------- clock / reset / DUT ----------------
  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [63:0] ALUResult;
  logic [63:0] WriteData;
  logic [63:0] ReadData;
  logic        dbg_valid;
  logic        dbg_ready;
  logic [63:0] dbg_data;
  logic        dbg_ovf;

  initial clk = 1'b0;
  always #10 clk = ~clk;

  dmem_responder #(
    .DEPTH_WORDS(DW),
    .FIFO_DEPTH (FD),
    .MMIO_BASE  (BASE)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .MemWrite (MemWrite),
    .ALUResult(ALUResult),
    .WriteData(WriteData),
    .ReadData (ReadData),
    .dbg_valid(dbg_valid),
    .dbg_ready(dbg_ready),
    .dbg_data (dbg_data),
    .dbg_ovf  (dbg_ovf)
  );

  // ---------------- reference model ----------------
  logic [63:0] ram_m [int];
  logic [63:0] exp_q [$];
  int          mcount;
  logic        movf;
  logic [31:0] mdrops;
  logic [63:0] mcycle;
  logic        rdy_cur;

  int checks;
  int errors;

  function automatic int ram_key(input logic [63:0] addr);
    return int'((addr >> 3) % DW);
  endfunction

  function automatic logic [63:0] model_read(input logic [63:0] addr);
    logic [63:0] off;
    if (addr < BASE) begin
      if (ram_m.exists(ram_key(addr))) return ram_m[ram_key(addr)];
      return 64'd0;
    end
    off = addr - BASE;
    case (off >> 3)
      64'd0:   return 64'(mcount);
      64'd1:   return 64'((movf ? 8 : 0) + ((mcount == FD) ? 4 : 0) + ((mcount == 0) ? 2 : 0));
      64'd2:   return mcycle;
      64'd3:   return {32'd0, mdrops};
      default: return 64'd0;
    endcase
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock cycle of traffic: drive, check registered-state outputs,
  // advance the model by the rules of the memory map, then take the edge.
  task automatic step(input logic we, input logic [63:0] addr, input logic [63:0] wd,
                      input bit chk, input string nm);
    bit          pop;
    bit          accepted;
    logic [63:0] off;
    MemWrite  = we;
    ALUResult = addr;
    WriteData = wd;
    dbg_ready = rdy_cur;
    #1;
    if (chk) check(nm, ReadData, model_read(addr));
    check("dbg_valid", {63'd0, dbg_valid}, 64'(mcount > 0));
    check("dbg_ovf", {63'd0, dbg_ovf}, {63'd0, movf});

    pop = rdy_cur && (mcount > 0);
    accepted = 1'b0;
    if (we && addr < BASE) begin
      ram_m[ram_key(addr)] = wd;
    end else if (we) begin
      off = addr - BASE;
      if ((off >> 3) == 64'd0) begin
        if (mcount < FD || pop) begin
          exp_q.push_back(wd);
          accepted = 1'b1;
        end else begin
          movf = 1'b1;
          if (mdrops != 32'hFFFF_FFFF) mdrops = mdrops + 32'd1;
        end
      end else if ((off >> 3) == 64'd1) begin
        if (wd[0]) movf = 1'b0;
      end
    end
    mcount = mcount + (accepted ? 1 : 0) - (pop ? 1 : 0);
    mcycle = mcycle + 64'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    MemWrite  = 1'b0;
    dbg_ready = rdy_cur;
    ALUResult = A_CY;
    #1;
    check("rst_valid", {63'd0, dbg_valid}, 64'd0);
    check("rst_data", dbg_data, 64'd0);
    check("rst_ovf", {63'd0, dbg_ovf}, 64'd0);
    check("rst_cycle", ReadData, 64'd0);
    ALUResult = A_DR;
    #1;
    check("rst_drops", ReadData, 64'd0);
    exp_q.delete();
    mcount = 0;
    movf   = 1'b0;
    mdrops = '0;
    mcycle = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // ---------------- scoreboard monitor ----------------
  // Samples on the falling edge, where the next rising edge's handshake
  // inputs are already stable.
  always @(negedge clk) begin
    if (reset && dbg_valid && dbg_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dbg_pop actual=%h required=none (queue empty) t=%0t", dbg_data, $time);
      end else begin
        check("dbg_data", dbg_data, exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [63:0] rand_addrs [10];

  initial begin
    checks    = 0;
    errors    = 0;
    rdy_cur   = 1'b0;
    reset     = 1'b0;
    MemWrite  = 1'b0;
    ALUResult = '0;
    WriteData = '0;
    dbg_ready = 1'b0;
    mcount    = 0;
    movf      = 1'b0;
    mdrops    = '0;
    mcycle    = '0;
    rand_addrs = '{64'h0, 64'h8, 64'h40, 64'h7F8, 64'h800, A_TX, A_TX, A_ST, A_CY, A_DR};

    do_reset();

    // RAM: store, aligned/unaligned reads, aliasing, read-during-write
    step(1'b1, 64'h40, PAT, 1'b0, "ram_w");
    step(1'b0, 64'h40, 64'd0, 1'b1, "ram_r40");
    step(1'b0, 64'h47, 64'd0, 1'b1, "ram_r47");
    step(1'b0, 64'h40 + 64'(8 * DW), 64'd0, 1'b1, "ram_alias");
    step(1'b1, 64'h40, 64'h1111_2222_3333_4444, 1'b1, "ram_rw_old");
    step(1'b0, 64'h40, 64'd0, 1'b1, "ram_new");
    step(1'b1, 64'h40, PAT, 1'b1, "ram_restore");

    // FIFO fill, overflow, then ordered drain
    rdy_cur = 1'b0;
    for (int i = 1; i <= 4; i++) step(1'b1, A_TX, 64'(i), 1'b1, "tx_fill");
    step(1'b0, A_ST, 64'd0, 1'b1, "status_full");
    step(1'b0, A_TX, 64'd0, 1'b1, "tx_count4");
    step(1'b1, A_TX, 64'd5, 1'b1, "tx_drop");
    step(1'b0, A_DR, 64'd0, 1'b1, "drops1");
    step(1'b0, A_ST, 64'd0, 1'b1, "status_ovf");
    rdy_cur = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b0, A_UN, 64'd0, 1'b1, "drain");
    step(1'b0, A_ST, 64'd0, 1'b1, "status_empty");

    // Push into a full FIFO while it is popping
    rdy_cur = 1'b0;
    for (int i = 11; i <= 14; i++) step(1'b1, A_TX, 64'(i), 1'b0, "tx_fill2");
    rdy_cur = 1'b1;
    step(1'b1, A_TX, 64'd9, 1'b1, "push_pop_full");
    step(1'b0, A_DR, 64'd0, 1'b1, "drops_same");
    for (int i = 0; i < 6; i++) step(1'b0, A_TX, 64'd0, 1'b1, "drain2");

    // Overflow clear, then re-overflow, then a write that does not clear
    step(1'b1, A_ST, 64'd1, 1'b1, "ovf_clear");
    step(1'b0, A_ST, 64'd0, 1'b1, "status_clr");
    rdy_cur = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b1, A_TX, 64'(100 + i), 1'b0, "tx_fill3");
    step(1'b1, A_ST, 64'd2, 1'b1, "ovf_noclear");
    step(1'b0, A_DR, 64'd0, 1'b1, "drops2");
    rdy_cur = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b0, A_ST, 64'd0, 1'b1, "drain3");

    // Cycle counter, read-only registers, unmapped offset
    step(1'b0, A_CY, 64'd0, 1'b1, "cycle_a");
    repeat (7) step(1'b0, A_UN, 64'd0, 1'b0, "idle");
    step(1'b0, A_CY, 64'd0, 1'b1, "cycle_b");
    step(1'b1, A_CY, 64'd123, 1'b1, "cycle_wr");
    step(1'b1, A_DR, 64'd0, 1'b1, "drops_wr");
    step(1'b0, A_DR, 64'd0, 1'b1, "drops_ro");
    step(1'b1, A_UN, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, "unmapped_wr");
    step(1'b0, A_UN, 64'd0, 1'b1, "unmapped_rd");
    step(1'b0, A_ST, 64'd0, 1'b1, "status_after_un");
    step(1'b0, A_TX, 64'd0, 1'b1, "tx_after_un");
    step(1'b0, 64'h40, 64'd0, 1'b1, "ram_after_un");

    // Reset mid-stream discards FIFO; RAM survives
    rdy_cur = 1'b0;
    step(1'b1, A_TX, 64'hAA, 1'b0, "pre_rst");
    step(1'b1, A_TX, 64'hBB, 1'b0, "pre_rst");
    do_reset();
    step(1'b0, 64'h40, 64'd0, 1'b1, "ram_keep");
    step(1'b0, A_TX, 64'd0, 1'b1, "tx_after_rst");

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [63:0] a;
      logic        we;
      logic [63:0] wd;
      bit          chk;
      rdy_cur = ($urandom_range(0, 9) < 3);
      a  = rand_addrs[$urandom_range(0, 9)];
      if ($urandom_range(0, 19) == 0) a = A_ST;
      we = $urandom_range(0, 1);
      wd = {$urandom, $urandom};
      if (a == A_ST) wd[0] = ($urandom_range(0, 3) == 0);
      chk = (a >= BASE) || ram_m.exists(ram_key(a));
      step(we, a, wd, chk, "rand");
    end

    // Final drain and leftover check
    rdy_cur = 1'b1;
    for (int i = 0; i < FD + 2; i++) step(1'b0, A_TX, 64'd0, 1'b1, "final_drain");
    check("leftover", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
